uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

- Shares the single UART transmit user port (valid/ready byte stream feeding the TX FIFO/driver) between `P_NUM_REQ` byte-stream requesters.
- Arbitration is round-robin with packet lock: a grant is held until the requester's `last` byte is accepted, or until the requester stalls past a timeout.
- Sits between software/DMA byte sources and the UART IP's `user_tx` interface.

## Interface
Parameters:
- `P_NUM_REQ`, default 4: number of requesters, 2..16.
- `P_DATA_WIDTH`, default 8: byte width; fixed at 8.
- `P_IDLE_TIMEOUT`, default 64: stall cycles before a grant is revoked; 0 disables the timeout.

Ports:
- `clock`  in  1  single clock; every flop is on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `i_req_valid`  in  P_NUM_REQ  per-requester byte valid.
- `i_req_data`  in  P_NUM_REQ*8  flattened; requester k occupies [8k+7:8k].
- `i_req_last`  in  P_NUM_REQ  final byte of the packet.
- `o_req_ready`  out  P_NUM_REQ  per-requester accept; at most one bit high.
- `o_user_tx_valid`  out  1  registered byte valid toward the UART.
- `o_user_tx_data`  out  8  registered byte.
- `i_user_tx_ready`  in  1  UART accepts; handshake is valid & ready in the same cycle.
- `o_grant_id`  out  $clog2(P_NUM_REQ)  current/last granted requester.
- `o_busy`  out  1  high when state ≠ IDLE or the output register is full.
- `o_timeout`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE, TAG (only with `UART_ARB_TAG_EN`), XFER.
- IDLE:
  - Round-robin pick among `i_req_valid`, searching upward from `rr_ptr`, with wrap-around.
  - If any requester is valid: latch `o_grant_id` = winner and go to XFER (or to TAG when enabled).
  - If none is valid: stay in IDLE.
- XFER:
  - `o_req_ready[g]` = ~`o_user_tx_valid` | `i_user_tx_ready`. All other ready bits are 0.
  - On a handshake with requester g, the byte is loaded into the output register and `o_user_tx_valid` is set.
  - `o_user_tx_valid` clears on a UART handshake when no new byte is loaded in the same cycle.
  - An accepted byte with `last`=1 moves the state to IDLE and sets `rr_ptr` = g+1 (mod P_NUM_REQ).
- Timeout:
  - The counter increments in each XFER cycle where `i_req_valid[g]`=0, and clears on every acceptance.
  - When the count equals P_IDLE_TIMEOUT: pulse `o_timeout`, go to IDLE, and set `rr_ptr` = g+1.
  - The partial packet is not flushed.
  - Counter width is $clog2(P_IDLE_TIMEOUT+1); it saturates and never wraps.
- Simultaneous events:
  - Acceptance in the same cycle as the timeout threshold: the acceptance wins and no timeout fires.
  - `last` accepted while the output register is still draining: the state goes to IDLE anyway; the drain completes independently.
- Reset values: state IDLE; `rr_ptr` 0; counter 0; `o_req_ready` 0; `o_user_tx_valid` 0; `o_user_tx_data` 0; `o_grant_id` 0; `o_busy` 0; `o_timeout` 0.
- Reset asserted mid-packet drops the held byte immediately, asynchronously.

## Timing
- Request-to-ready latency: requester valid in IDLE at cycle n → `o_req_ready` high at n+1 (n+2 with TAG).
- Byte latency: a byte accepted at cycle n appears on `o_user_tx_data` at n+1.
- Throughput: one byte per cycle while the UART holds `i_user_tx_ready` high.
- Packet boundary: one IDLE bubble cycle between consecutive packets.
- Output hold: `o_user_tx_valid`/`o_user_tx_data` stay stable until the UART handshake.

## Configuration
- `UART_ARB_TAG_EN` defined:
  - After a grant, the TAG state waits for the output register to be free, then loads 8'hA0 | grant_id.
  - The next state is XFER; no requester is ready during TAG.
  - Every packet on the UART is therefore prefixed with one tag byte.
- `UART_ARB_TAG_EN` undefined: the TAG state is absent and IDLE goes directly to XFER.

## Structure
- Package `uart_arb_pkg`:
  - State enum.
  - `TAG_BASE` = 8'hA0.
  - Requester-ID width function.
- Sub-module `uart_rr_pick`:
  - Combinational rotating-priority picker.
  - Inputs: request vector, `rr_ptr`.
  - Outputs: `any`, `winner_id`.
- The FSM, output register and timeout counter live in the top module.

## Test plan
- Req0 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33), UART always ready → bytes appear at cycles 2, 3, 4; `rr_ptr`=1 afterwards.
- Req1 and req3 valid together, `rr_ptr`=2 → req3 is granted first, then req1 after req3's `last`.
- UART ready held low for 10 cycles mid-packet → `o_user_tx_data` is stable and `o_req_ready` is 0 throughout; no byte is lost or duplicated.
- Req2 stalls after 1 byte with P_IDLE_TIMEOUT=4 → `o_timeout` pulses 4 cycles later; the next valid requester is granted.
- With `UART_ARB_TAG_EN`, req1 sends 0x55 → UART sees 0xA1 then 0x55.
- Reset asserted while `o_user_tx_valid`=1 → all outputs are 0 immediately; after release, req0 is granted first.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Build option: UART_ARB_TAG_EN prefixes each packet with a tag byte.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_t;

    localparam logic [7:0] TAG_BASE = 8'hA0;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set request at or above rr_ptr,
// wrapping around to requester 0.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int P_NUM_REQ = 4,
    localparam int ID_W = id_width(P_NUM_REQ)
) (
    input  logic [P_NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]      rr_ptr,
    output logic                 any,
    output logic [ID_W-1:0]      winner_id
);

    int              sum;
    logic [ID_W-1:0] idx;

    // Walk from the lowest priority down so the last hit is the winner.
    always_comb begin
        any       = 1'b0;
        winner_id = '0;
        sum       = 0;
        idx       = '0;
        for (int i = P_NUM_REQ - 1; i >= 0; i--) begin
            sum = int'(rr_ptr) + i;
            if (sum >= P_NUM_REQ) begin
                sum = sum - P_NUM_REQ;
            end
            idx = ID_W'(sum);
            if (req[idx]) begin
                any       = 1'b1;
                winner_id = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter in front of the UART user_tx port.
// Build option: UART_ARB_TAG_EN sends 8'hA0|grant_id ahead of each packet.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int P_NUM_REQ      = 4,
    parameter int P_DATA_WIDTH   = 8,
    parameter int P_IDLE_TIMEOUT = 64
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [P_NUM_REQ-1:0]              i_req_valid,
    input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data,
    input  logic [P_NUM_REQ-1:0]              i_req_last,
    output logic [P_NUM_REQ-1:0]              o_req_ready,
    output logic                              o_user_tx_valid,
    output logic [P_DATA_WIDTH-1:0]           o_user_tx_data,
    input  logic                              i_user_tx_ready,
    output logic [$clog2(P_NUM_REQ)-1:0]      o_grant_id,
    output logic                              o_busy,
    output logic                              o_timeout
);

    localparam int ID_W  = id_width(P_NUM_REQ);
    localparam int CNT_W = cnt_width(P_IDLE_TIMEOUT);
    localparam bit TO_EN = (P_IDLE_TIMEOUT != 0);
`ifdef UART_ARB_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    arb_state_t              state;
    logic [ID_W-1:0]         rr_ptr;
    logic [CNT_W-1:0]        cnt;
    logic                    any;
    logic [ID_W-1:0]         winner;
    logic [ID_W-1:0]         ptr_after;
    logic                    ready_g;
    logic                    accept;
    logic                    tag_load;
    logic                    to_hit;
    logic [P_DATA_WIDTH-1:0] tag_byte;
    logic [P_DATA_WIDTH-1:0] req_bytes [P_NUM_REQ];

    uart_rr_pick #(
        .P_NUM_REQ(P_NUM_REQ)
    ) u_pick (
        .req      (i_req_valid),
        .rr_ptr   (rr_ptr),
        .any      (any),
        .winner_id(winner)
    );

    always_comb begin
        for (int k = 0; k < P_NUM_REQ; k++) begin
            req_bytes[k] = i_req_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
        end
    end

    assign ready_g   = (state == ST_XFER)
                     && (!o_user_tx_valid || i_user_tx_ready);
    assign accept    = ready_g && i_req_valid[o_grant_id];
    assign tag_load  = (state == ST_TAG)
                     && (!o_user_tx_valid || i_user_tx_ready);
    assign ptr_after = (o_grant_id == ID_W'(P_NUM_REQ - 1))
                     ? '0 : o_grant_id + 1'b1;
    assign tag_byte  = P_DATA_WIDTH'(TAG_BASE)
                     | P_DATA_WIDTH'(o_grant_id);

    // A byte accepted on the threshold cycle keeps the grant alive.
    assign to_hit = TO_EN && (state == ST_XFER) && !accept
                  && (cnt == CNT_W'(P_IDLE_TIMEOUT));

    assign o_timeout = to_hit;
    assign o_busy    = (state != ST_IDLE) || o_user_tx_valid;

    always_comb begin
        o_req_ready             = '0;
        o_req_ready[o_grant_id] = ready_g;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            o_grant_id <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        o_grant_id <= winner;
                        cnt        <= '0;
                        state      <= TAG_EN ? ST_TAG : ST_XFER;
                    end
                end
                ST_TAG: begin
                    if (tag_load) begin
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (accept) begin
                        cnt <= '0;
                        if (i_req_last[o_grant_id]) begin
                            state  <= ST_IDLE;
                            rr_ptr <= ptr_after;
                        end
                    end else if (to_hit) begin
                        state  <= ST_IDLE;
                        rr_ptr <= ptr_after;
                    end else if (!i_req_valid[o_grant_id]
                                 && cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register drains on its own, independent of the FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_user_tx_valid <= 1'b0;
            o_user_tx_data  <= '0;
        end else if (accept) begin
            o_user_tx_valid <= 1'b1;
            o_user_tx_data  <= req_bytes[o_grant_id];
        end else if (tag_load) begin
            o_user_tx_valid <= 1'b1;
            o_user_tx_data  <= tag_byte;
        end else if (i_user_tx_ready) begin
            o_user_tx_valid <= 1'b0;
        end
    end

endmodule
